// File: rtl/ppm_tx_modulator_pkg.sv
// Shared types and helpers for the PPM transmit modulator: FSM state encoding and
// a constant log2 helper used to size chip/symbol counters and scan taps.
package ppm_tx_modulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PREAMBLE = 2'b01,
        ST_DATA     = 2'b10,
        ST_EMPTY    = 2'b11
    } tx_state_e;

    function automatic int ceil_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ppm_tx_modulator_if.sv
// Data symbol stream into the modulator: one symbol (pulse position) per transfer,
// with a last flag marking the final symbol of a frame.
interface ppm_tx_modulator_if #(
    parameter int SYM_W = 4
) ();
    logic [SYM_W-1:0] sym_data;
    logic             sym_valid;
    logic             sym_last;
    logic             sym_ready;

    modport master (
        output sym_data,
        output sym_valid,
        output sym_last,
        input  sym_ready
    );

    modport slave (
        input  sym_data,
        input  sym_valid,
        input  sym_last,
        output sym_ready
    );
endinterface

// File: rtl/ppm_tx_modulator_chip_counter.sv
// Chip position within a symbol plus preamble symbol count.
// Latency: registered counts, wrap/final strobes combinational from the registers.
// Backpressure: none; counts advance every cycle while run is high.
module ppm_chip_counter
    import ppm_tx_modulator_pkg::*;
#(
    parameter int SYMBOL_CHIPS     = 16,
    parameter int PREAMBLE_SYMBOLS = 32,
    localparam int SYM_W = ceil_log2(SYMBOL_CHIPS),
    localparam int CNT_W = ceil_log2(PREAMBLE_SYMBOLS) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             run,
    input  logic             count_sym,
    output logic [SYM_W-1:0] chip_count,
    output logic             chip_wrap,
    output logic [CNT_W-1:0] sym_count,
    output logic             sym_final
);

    logic [SYM_W-1:0] chip_count_q, chip_count_d;
    logic [CNT_W-1:0] sym_count_q, sym_count_d;

    assign chip_wrap  = (chip_count_q == SYM_W'(SYMBOL_CHIPS - 1));
    assign sym_final  = (sym_count_q == CNT_W'(PREAMBLE_SYMBOLS - 1));
    assign chip_count = chip_count_q;
    assign sym_count  = sym_count_q;

    always_comb begin
        chip_count_d = chip_count_q;
        sym_count_d  = sym_count_q;
        if (clear) begin
            chip_count_d = '0;
            sym_count_d  = '0;
        end else if (run) begin
            // SYMBOL_CHIPS is a power of two, so the chip counter wraps on overflow.
            chip_count_d = chip_count_q + SYM_W'(1);
            if (count_sym && chip_wrap && !sym_final) begin
                sym_count_d = sym_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chip_count_q <= '0;
            sym_count_q  <= '0;
        end else begin
            chip_count_q <= chip_count_d;
            sym_count_q  <= sym_count_d;
        end
    end

endmodule

// File: rtl/ppm_tx_modulator.sv
// PPM transmit modulator: preamble (two pulses per symbol) then one pulse per data symbol.
// Latency: dout/busy/preamble registered one cycle behind the chip they encode.
// Backpressure: sym_ready only on a symbol's final chip; a missing symbol yields an empty slot.
module ppm_tx_modulator
    import ppm_tx_modulator_pkg::*;
#(
    parameter int CHIP_BITS        = 1,
    parameter int SYMBOL_CHIPS     = 16,
    parameter int PREAMBLE_SYMBOLS = 32,
    localparam int SYM_W = ceil_log2(SYMBOL_CHIPS),
    localparam int CNT_W = ceil_log2(PREAMBLE_SYMBOLS) + 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [CHIP_BITS-1:0] pulse_amp,
    ppm_tx_modulator_if.slave    sym_if,
    output logic [CHIP_BITS-1:0] dout,
    output logic                 busy,
    output logic                 preamble,
    output logic                 underflow,
    output logic [1:0]           TX_state_SC,
    output logic [SYM_W-1:0]     TX_chip_count_SC,
    output logic [CNT_W-1:0]     TX_symbol_count_SC
);

    tx_state_e            state_q, state_d;
    logic [CHIP_BITS-1:0] amp_q, amp_d;
    logic [CHIP_BITS-1:0] dout_q, dout_d;
    logic [SYM_W-1:0]     held_data_q, held_data_d;
    logic                 held_last_q, held_last_d;
    logic                 busy_q, busy_d;
    logic                 preamble_q, preamble_d;
    logic                 underflow_q, underflow_d;

    logic [SYM_W-1:0]     chip_count;
    logic [CNT_W-1:0]     sym_count;
    logic                 chip_wrap;
    logic                 sym_final;
    logic                 start_acc;
    logic                 sym_ready;
    logic                 xfer;

    assign start_acc = (state_q == ST_IDLE) && start;

    ppm_chip_counter #(
        .SYMBOL_CHIPS     (SYMBOL_CHIPS),
        .PREAMBLE_SYMBOLS (PREAMBLE_SYMBOLS)
    ) u_chip_counter (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (start_acc),
        .run        (state_q != ST_IDLE),
        .count_sym  (state_q == ST_PREAMBLE),
        .chip_count (chip_count),
        .chip_wrap  (chip_wrap),
        .sym_count  (sym_count),
        .sym_final  (sym_final)
    );

    // A symbol is taken only at a data boundary, and never after the frame's last symbol.
    assign sym_ready = chip_wrap && (state_q != ST_IDLE) && !held_last_q &&
                       ((state_q != ST_PREAMBLE) || sym_final);
    assign xfer      = sym_if.sym_valid && sym_ready;

    always_comb begin
        state_d     = state_q;
        amp_d       = amp_q;
        held_data_d = held_data_q;
        held_last_d = held_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_PREAMBLE;
                    amp_d       = pulse_amp;
                    held_last_d = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (chip_wrap && sym_final) begin
                    state_d = xfer ? ST_DATA : ST_EMPTY;
                end
            end
            default: begin
                if (chip_wrap) begin
                    if (held_last_q) begin
                        state_d     = ST_IDLE;
                        held_last_d = 1'b0;
                    end else begin
                        state_d = xfer ? ST_DATA : ST_EMPTY;
                    end
                end
            end
        endcase

        if (xfer) begin
            held_data_d = sym_if.sym_data;
            held_last_d = sym_if.sym_last;
        end
    end

    always_comb begin
        dout_d = '0;
        case (state_q)
            ST_PREAMBLE: begin
                if ((chip_count == '0) || (chip_count == SYM_W'(SYMBOL_CHIPS / 2))) begin
                    dout_d = amp_q;
                end
            end
            ST_DATA: begin
                if (chip_count == held_data_q) begin
                    dout_d = amp_q;
                end
            end
            default: dout_d = '0;
        endcase
        busy_d      = (state_q != ST_IDLE);
        preamble_d  = (state_q == ST_PREAMBLE);
        underflow_d = sym_ready && !sym_if.sym_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            amp_q       <= '0;
            dout_q      <= '0;
            held_data_q <= '0;
            held_last_q <= 1'b0;
            busy_q      <= 1'b0;
            preamble_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            amp_q       <= amp_d;
            dout_q      <= dout_d;
            held_data_q <= held_data_d;
            held_last_q <= held_last_d;
            busy_q      <= busy_d;
            preamble_q  <= preamble_d;
            underflow_q <= underflow_d;
        end
    end

    assign sym_if.sym_ready   = sym_ready;
    assign dout               = dout_q;
    assign busy               = busy_q;
    assign preamble           = preamble_q;
    assign underflow          = underflow_q;
    assign TX_state_SC        = state_q;
    assign TX_chip_count_SC   = chip_count;
    assign TX_symbol_count_SC = sym_count;

endmodule
